spi_result_tx: RTL and testbench
================================

SPI_RESULT_TX -- requirements
Module: spi_result_tx

Interface
REQ-001 SHALL have parameter DW, default 12, meaning width of each real/imag sample.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter SCK_DIV, default 4, meaning CLK cycles per SCK period (even, >=2).
REQ-004 SHALL have parameter GAP_CYC, default 2, meaning CLK cycles CS stays high between words.
REQ-005 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port IEN  input  1  input sample valid (FFT result strobe).
REQ-008 SHALL have port IREAL  input  DW  signed real part of the result.
REQ-009 SHALL have port IIMAG  input  DW  signed imaginary part of the result.
REQ-010 SHALL have port IRDY  output  1  high when FIFO not full.
REQ-011 SHALL have port OVF  output  1  sticky overflow flag.
REQ-012 SHALL have port BUSY  output  1  high when FIFO non-empty or state != IDLE.
REQ-013 SHALL have port CS  output  1  SPI chip select, active low.
REQ-014 SHALL have port SCK  output  1  SPI clock, mode 0 (idle low).
REQ-015 SHALL have port MOSI  output  1  SPI serial data.

Function
REQ-016 Push: IEN=1 and FIFO not full SHALL write {IREAL,IIMAG} into the FIFO that cycle.
REQ-017 IEN=1 while FIFO full SHALL drop the sample and set OVF=1, even if a pop occurs the same cycle; OVF clears only on reset.
REQ-018 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-019 FSM states SHALL be IDLE, LOAD, SHIFT, GAP.
REQ-020 IDLE -> LOAD when FIFO non-empty; IDLE otherwise holds CS=1, SCK=0, MOSI=0.
REQ-021 LOAD (1 cycle): pop FIFO head into 2*DW shift register, CS=0, MOSI=bit 2*DW-1; -> SHIFT.
REQ-022 Word format SHALL be IREAL[DW-1:0] then IIMAG[DW-1:0], MSB first, 2*DW bits.
REQ-023 SHIFT: SCK low for SCK_DIV/2 cycles then high for SCK_DIV/2 cycles per bit; MOSI changes only with SCK falling edge (or in LOAD) and is stable across each rising edge.
REQ-024 After the 2*DW-th SCK falling edge, -> GAP with CS=1, SCK=0.
REQ-025 GAP lasts GAP_CYC cycles, then -> IDLE; next word starts no sooner.
REQ-026 Word latency with defaults: 1 + 24*4 + 2 = 99 CLK cycles from LOAD to next possible LOAD.
REQ-027 CS, SCK, MOSI SHALL be driven directly from flops (no glitches).
REQ-028 Bit counter SHALL be ceil(log2(2*DW+1)) bits; FIFO pointers wrap modulo DEPTH with an extra wrap bit for full/empty.

Reset
REQ-029 RST=1 SHALL asynchronously force: state IDLE, FIFO empty, OVF=0, BUSY=0, IRDY=1, CS=1, SCK=0, MOSI=0.
REQ-030 Reset asserted mid-word SHALL abort the word immediately; no partial word resumes after release.
REQ-031 First push SHALL be accepted on the first rising CLK edge after RST deasserts.

Structure
REQ-032 Package fft_spi_pkg SHALL hold DW default, WORD_W=2*DW, and the FSM state enumeration.
REQ-033 FIFO SHALL be a separate sub-module sync_fifo (parameters width, depth; ports push, pop, wdata, rdata, full, empty).
REQ-034 FSM, SCK divider, bit counter and shift register SHALL reside in spi_result_tx.

Verification
REQ-035 Single push IREAL=12'hA5C, IIMAG=12'h3F0 -> CS low 97 cycles, 24 bits captured on SCK rise = 24'hA5C3F0, CS high >=2 cycles.
REQ-036 Push 16 samples back-to-back (0x001..0x010 real, inverse imag) -> IRDY low after 16th only if no pop yet; all 16 words received in order, OVF=0.
REQ-037 Push 20 samples in 20 consecutive cycles -> at most 17 accepted (one popped by LOAD), OVF=1, received words match the accepted ones exactly.
REQ-038 Assert RST for 1 cycle at bit 10 of a word -> CS=1, SCK=0 same cycle; BUSY=0; no further SCK edges until new push.
REQ-039 Negative extremes IREAL=12'h800, IIMAG=12'hFFF -> received 24'h800FFF; MOSI never changes within 1 CLK of SCK rising edge.
REQ-040 Parameter sweep SCK_DIV=2, GAP_CYC=1 -> word period 1+48+1 = 50 cycles, data intact.

Source files
------------

// File: rtl/fft_spi_pkg.sv
// Shared widths and FSM encoding for the FFT result SPI transmitter.
// Imported by the FIFO and the transmitter top.
package fft_spi_pkg;

    localparam int DW_DEFAULT = 12;
    localparam int WORD_W     = 2 * DW_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra wrap bit on each pointer for full/empty.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo
    import fft_spi_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_result_tx.sv
// Buffers {real,imag} FFT results and ships each as one MSB-first
// SPI mode-0 word; CS, SCK and MOSI all come straight from flops.
module spi_result_tx
    import fft_spi_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int DEPTH   = 16,
    parameter int SCK_DIV = 4,
    parameter int GAP_CYC = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IEN,
    input  logic [DW-1:0] IREAL,
    input  logic [DW-1:0] IIMAG,
    output logic          IRDY,
    output logic          OVF,
    output logic          BUSY,
    output logic          CS,
    output logic          SCK,
    output logic          MOSI
);
    localparam int WW   = 2 * DW;
    localparam int HALF = SCK_DIV / 2;
    localparam int CW   = $clog2(WW + 1);
    localparam int VW   = $clog2(SCK_DIV);
    localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [VW-1:0] DIV_MID  = VW'(HALF - 1);
    localparam logic [VW-1:0] DIV_END  = VW'(SCK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WW - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    tx_state_e     state_q, state_d;
    logic [WW-1:0] sr_q, sr_d;
    logic [VW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cs_q, cs_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          ovf_q, ovf_d;
    logic          go;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [WW-1:0] fifo_rdata;

    sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (IEN),
        .pop   (fifo_pop),
        .wdata ({IREAL, IIMAG}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign IRDY = !fifo_full;
    assign OVF  = ovf_q;
    assign BUSY = !fifo_empty || (state_q != IDLE);
    assign CS   = cs_q;
    assign SCK  = sck_q;
    assign MOSI = mosi_q;

    // Next state, SCK divider, bit counter, shifter and pin values
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        ovf_d    = ovf_q | (IEN & fifo_full);
        fifo_pop = 1'b0;
        go       = 1'b0;
        unique case (state_q)
            IDLE: begin
                go = !fifo_empty;
            end
            LOAD: begin
                fifo_pop = 1'b1;
                div_d    = '0;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_MID) begin
                    sck_d = 1'b1;
                end else if (div_q == DIV_END) begin
                    div_d  = '0;
                    sck_d  = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                    sr_d   = sr_q << 1;
                    mosi_d = sr_q[WW-2];
                    if (cnt_q == CNT_LAST) begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    go      = !fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Head word is visible before its pop, so CS and the MSB
        // are registered on the edge that enters LOAD.
        if (go) begin
            state_d = LOAD;
            cs_d    = 1'b0;
            sr_d    = fifo_rdata;
            mosi_d  = fifo_rdata[WW-1];
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_result_tx.sv
// Bench for spi_result_tx: timeline model of each word plus an SPI
// receiver, and a second instance with fast SCK and short gap.
module tb_spi_result_tx;

    localparam int DW    = 12;
    localparam int WW    = 2 * DW;
    localparam int DEPTH = 16;
    localparam int DIV   = 4;
    localparam int GAPC  = 2;
    localparam int HALF  = DIV / 2;
    localparam int W     = WW * DIV;
    localparam int L     = 1 + W + GAPC;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IEN = 1'b0;
    logic [DW-1:0] IREAL = '0;
    logic [DW-1:0] IIMAG = '0;
    logic          IRDY, OVF, BUSY, CS, SCK, MOSI;

    logic          IEN2 = 1'b0;
    logic [DW-1:0] RE2 = '0;
    logic [DW-1:0] IM2 = '0;
    logic          IRDY2, OVF2, BUSY2, CS2, SCK2, MOSI2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    spi_result_tx #(
        .DW(DW), .DEPTH(DEPTH), .SCK_DIV(DIV), .GAP_CYC(GAPC)
    ) dut (
        .CLK(CLK), .RST(RST), .IEN(IEN), .IREAL(IREAL), .IIMAG(IIMAG),
        .IRDY(IRDY), .OVF(OVF), .BUSY(BUSY),
        .CS(CS), .SCK(SCK), .MOSI(MOSI)
    );

    spi_result_tx #(
        .DW(DW), .DEPTH(DEPTH), .SCK_DIV(2), .GAP_CYC(1)
    ) dut2 (
        .CLK(CLK), .RST(RST), .IEN(IEN2), .IREAL(RE2), .IIMAG(IM2),
        .IRDY(IRDY2), .OVF(OVF2), .BUSY(BUSY2),
        .CS(CS2), .SCK(SCK2), .MOSI(MOSI2)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                         name, act, exp, cyc);
        end
    endtask

    // Model: FIFO as a queue; each word occupies L cycles from LOAD
    logic [WW-1:0] mq[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] m_cur = '0;
    bit            m_act = 0;
    int            m_t   = 0;
    bit            m_ovf = 0;
    int            acc   = 0;
    bit            prev_load;
    bit            start;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            mq.delete();
            exp_q.delete();
            m_act = 0;
            m_t   = 0;
            m_ovf = 0;
        end else begin
            prev_load = m_act && (m_t == 0);
            start = (!m_act || m_t == L - 1) && (mq.size() > 0);
            if (start) begin
                m_cur = mq[0];
                m_act = 1;
                m_t   = 0;
                exp_q.push_back(mq[0]);
            end else if (m_act) begin
                if (m_t == L - 1) m_act = 0;
                else m_t++;
            end
            if (IEN) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else begin
                    mq.push_back({IREAL, IIMAG});
                    acc++;
                end
            end
            if (prev_load) void'(mq.pop_front());
        end
    end

    // Per-cycle compare plus SPI receiver on the main instance
    logic          cs_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0;
    bit            rose_p = 0;
    logic [WW-1:0] rx_w = '0;
    int            rx_n = 0;
    int            rises = 0;
    int            cs_low = 0, last_low = 0;
    int            last_fall = -1, last_per = 0;
    logic [WW-1:0] rx_log[$];
    logic          e_cs, e_sck, e_mosi;
    int            u;

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_cs", CS, 1'b1);
            chk("rst_sck", SCK, 1'b0);
            chk("rst_mosi", MOSI, 1'b0);
            chk("rst_busy", BUSY, 1'b0);
            chk("rst_irdy", IRDY, 1'b1);
            chk("rst_ovf", OVF, 1'b0);
            rx_n   = 0;
            rose_p = 0;
        end else begin
            e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0;
            if (m_act && m_t == 0) begin
                e_cs = 1'b0; e_mosi = m_cur[WW-1];
            end else if (m_act && m_t <= W) begin
                u      = m_t - 1;
                e_cs   = 1'b0;
                e_sck  = (u % DIV) >= HALF;
                e_mosi = m_cur[WW - 1 - u / DIV];
            end
            chk("cs", CS, e_cs);
            chk("sck", SCK, e_sck);
            chk("mosi", MOSI, e_mosi);
            chk("busy", BUSY, (mq.size() > 0) || m_act);
            chk("irdy", IRDY, mq.size() < DEPTH);
            chk("ovf", OVF, m_ovf);
            if (rose_p) chk("mosi_after_rise", MOSI, mosi_p);
            rose_p = 0;
            if (SCK && !sck_p) begin
                chk("mosi_at_rise", MOSI, mosi_p);
                rx_w = {rx_w[WW-2:0], MOSI};
                rx_n++;
                rises++;
                rose_p = 1;
            end
            if (!CS && cs_p) begin
                if (last_fall >= 0) last_per = cyc - last_fall;
                last_fall = cyc;
                cs_low = 0;
            end
            if (!CS) cs_low++;
            if (CS && !cs_p) begin
                last_low = cs_low;
                chk("rx_bits", rx_n, WW);
                if (exp_q.size() == 0) chk("rx_extra_word", rx_w, 0);
                else chk("rx_word", rx_w, exp_q.pop_front());
                rx_log.push_back(rx_w);
                rx_n = 0;
            end
        end
        cs_p = CS; sck_p = SCK; mosi_p = MOSI;
    end

    // Receiver on the fast instance
    logic          cs2_p = 1'b1, sck2_p = 1'b0;
    logic [WW-1:0] w2 = '0;
    logic [WW-1:0] words2[$];
    int            low2 = 0, lowlast2 = 0, f2_last = -1, per2 = 0;

    always @(negedge CLK) begin
        if (!CS2 && cs2_p) begin
            if (f2_last >= 0) per2 = cyc - f2_last;
            f2_last = cyc;
            low2 = 0;
        end
        if (!CS2) low2++;
        if (SCK2 && !sck2_p) w2 = {w2[WW-2:0], MOSI2};
        if (CS2 && !cs2_p && !RST) begin
            lowlast2 = low2;
            words2.push_back(w2);
        end
        cs2_p = CS2; sck2_p = SCK2;
    end

    task automatic push1(input logic [DW-1:0] re, input logic [DW-1:0] im);
        IEN = 1'b1; IREAL = re; IIMAG = im;
        @(posedge CLK); #2;
        IEN = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSY && n < budget);
        chk("idle_timeout", BUSY, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0, r0, k;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        // first push lands on the first edge after release
        push1(12'hA5C, 12'h3F0);
        wait_idle(300);
        chk("t1_word", rx_log[rx_log.size() - 1], 24'hA5C3F0);
        chk("t1_cs_low", last_low, 97);
        chk("t1_count", rx_log.size(), 1);

        // 16 back-to-back samples
        n0 = rx_log.size(); a0 = acc;
        for (int i = 1; i <= 16; i++) begin
            IEN = 1'b1; IREAL = 12'(i); IIMAG = 12'(-i);
            @(posedge CLK); #2;
        end
        IEN = 1'b0;
        wait_idle(2000);
        chk("t2_acc", acc - a0, 16);
        chk("t2_words", rx_log.size() - n0, 16);
        chk("t2_first", rx_log[n0], 24'h001FFF);
        chk("t2_last", rx_log[n0 + 15], 24'h010FF0);
        chk("t2_period", last_per, 99);
        chk("t2_ovf", OVF, 1'b0);

        // 20 samples in 20 cycles overflow the FIFO
        n0 = rx_log.size(); a0 = acc;
        for (int i = 0; i < 20; i++) begin
            IEN = 1'b1; IREAL = 12'h100 + 12'(i); IIMAG = 12'h200 + 12'(i);
            @(posedge CLK); #2;
        end
        IEN = 1'b0;
        chk("t3_ovf", OVF, 1'b1);
        wait_idle(2200);
        chk("t3_acc", acc - a0, 17);
        chk("t3_words", rx_log.size() - n0, 17);
        chk("t3_word16", rx_log[n0 + 16], 24'h110210);
        chk("t3_ovf_sticky", OVF, 1'b1);

        // reset in the middle of a word
        n0 = rx_log.size();
        push1(12'h5A5, 12'hC3C);
        r0 = rises; k = 0;
        while (rises - r0 < 10 && k < 300) begin
            @(negedge CLK); k++;
        end
        chk("t4_reach_bit10", rises - r0, 10);
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("t4_cs", CS, 1'b1);
        chk("t4_sck", SCK, 1'b0);
        chk("t4_busy", BUSY, 1'b0);
        chk("t4_irdy", IRDY, 1'b1);
        chk("t4_ovf", OVF, 1'b0);
        @(posedge CLK); #2;
        RST = 1'b0;
        r0 = rises;
        repeat (200) @(negedge CLK);
        chk("t4_no_sck", rises - r0, 0);
        chk("t4_no_word", rx_log.size() - n0, 0);

        // negative extremes
        push1(12'h800, 12'hFFF);
        wait_idle(300);
        chk("t5_word", rx_log[rx_log.size() - 1], 24'h800FFF);
        chk("t5_cs_low", last_low, 97);

        // fast SCK, one-cycle gap instance
        IEN2 = 1'b1; RE2 = 12'h123; IM2 = 12'h456;
        @(posedge CLK); #2;
        RE2 = 12'hABC; IM2 = 12'hDEF;
        @(posedge CLK); #2;
        IEN2 = 1'b0;
        k = 0;
        while (words2.size() < 2 && k < 400) begin
            @(negedge CLK); k++;
        end
        chk("t6_words", words2.size(), 2);
        if (words2.size() >= 2) begin
            chk("t6_w0", words2[0], 24'h123456);
            chk("t6_w1", words2[1], 24'hABCDEF);
        end
        chk("t6_cs_low", lowlast2, 49);
        chk("t6_period", per2, 50);
        repeat (5) @(negedge CLK);
        chk("t6_busy", BUSY2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
